key_array_funcmod: RTL and testbench
====================================

Name: key_array_funcmod

Overview:
- Parametrised N-channel push-button front end for active-low keys.
- Per key: synchronises the pin, debounces press and release, and classifies each press as short or long.
- Emits one-cycle trigger pulses plus a debounced held level.
- Sits between the board key pins and the control/menu logic. Channels are fully independent.

Parameters:
- NKEY, 4, number of key channels.
- T10MS, 500_000, debounce window in CLOCK cycles.
- T3S, 150_000_000, long-press threshold in CLOCK cycles, counted from the end of press debounce.
- TREP, 10_000_000, auto-repeat period in CLOCK cycles (used only with the optional feature).

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous active-low reset.
- KEY  in  NKEY  raw key pins, active-low (1 = released).
- oShort  out  NKEY  one-cycle pulse per channel on short click.
- oLong  out  NKEY  one-cycle pulse per channel on long press (and repeats, if enabled).
- oHeld  out  NKEY  debounced pressed level per channel.

Behaviour:
- Reset (RESET low, asynchronous): oShort = 0, oLong = 0, oHeld = 0, synchroniser flops = 1, FSM = IDLE, counters = 0.
- Synchroniser: two flops per channel, F2 <= F1 <= KEY[k].
  - isH2L = (F2 == 1 && F1 == 0); isL2H = (F2 == 0 && F1 == 1).
  - Pin-to-F1 latency is 1 cycle.
- Per-channel FSM with one counter C of width $clog2(max(T3S, TREP)):
  - IDLE: on isH2L -> DEB_DN, C = 0.
  - DEB_DN: C increments. At C == T10MS-1, C = 0, then:
    - F1 == 0 -> HOLD, oHeld = 1.
    - F1 == 1 (glitch) -> IDLE, no pulse.
  - HOLD:
    - isL2H -> oShort[k] = 1 for one cycle, oHeld = 0, -> DEB_UP, C = 0.
    - Else if C == T3S-1 -> oLong[k] = 1 for one cycle, -> WAIT_UP, C = 0.
    - Else C increments.
    - isL2H has priority over the threshold in the same cycle (result is a short click).
  - WAIT_UP: on isL2H -> oHeld = 0, -> DEB_UP, C = 0.
  - DEB_UP: C increments. At C == T10MS-1 -> IDLE, C = 0. Edges during DEB_UP are ignored.
- Pulse outputs are registered. A pulse is asserted in the cycle after the FSM samples the qualifying condition and is deasserted the next cycle.
- Exactly one of oShort/oLong per press, except repeats under the optional feature.
- Channels share no state. Simultaneous events on different channels give simultaneous pulses.
- A press shorter than the debounce window produces no output.
- Reset mid-press: the channel returns to IDLE. The still-low key is not detected until the next H2L.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined: in WAIT_UP, C counts. At C == TREP-1, oLong[k] pulses for one cycle and C = 0, repeating until isL2H. The release exits with no extra pulse.
- Undefined: WAIT_UP holds C at 0 and no repeat logic is synthesised. Behaviour is exactly as above.

Decomposition:
- Package key_pkg holds:
  - FSM state enum: IDLE, DEB_DN, HOLD, WAIT_UP, DEB_UP.
  - Default timing constants.
  - A counter-width function.
- Sub-module key_chan: one channel, with synchroniser, FSM and counter. It is instantiated NKEY times by a generate loop in key_array_funcmod, which only concatenates outputs.

Test Plan (sim overrides: NKEY=2, T10MS=10, T3S=100, TREP=20):
- Key0 low for 50 cycles, then high -> oShort[0] one cycle after release detection, oHeld[0] high ~40 cycles, oLong = 0, key1 outputs 0.
- Key0 low for 200 cycles -> oLong[0] pulse ~112 cycles after the falling edge, no oShort, oHeld[0] drops on release.
- Key0 low for only 5 cycles -> no pulses, oHeld stays 0, FSM back to IDLE after 10-cycle window.
- Key0 and key1 pressed on the same cycle, both 50 cycles -> oShort[1:0] = 2'b11 in the same cycle.
- Bounce: 3 toggles within 6 cycles on release -> exactly one oShort, no spurious second press.
- Hold key0 for 200 cycles, assert RESET at cycle 150 -> all outputs 0 immediately, no pulse after reset release. With KEY_AUTOREPEAT_EN and the same hold uninterrupted -> oLong[0] pulses at ~112, ~132, ~152, ...

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the active-low key front end.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_DN,
    HOLD,
    WAIT_UP,
    DEB_UP
  } keyState_e;

  localparam int DEF_NKEY  = 4;
  localparam int DEF_T10MS = 500_000;
  localparam int DEF_T3S   = 150_000_000;
  localparam int DEF_TREP  = 10_000_000;

  // Counter must reach the larger of the long-press and repeat thresholds.
  function automatic int cntWidth(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: two-flop synchroniser, press/release debounce, short/long classification.
// Auto-repeat of the long pulse while held is enabled by defining KEY_AUTOREPEAT_EN.
module key_chan
  import key_pkg::*;
#(
  parameter int T10MS = DEF_T10MS,
  parameter int T3S   = DEF_T3S,
  parameter int TREP  = DEF_TREP
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic key,
  output logic oShort,
  output logic oLong,
  output logic oHeld
);

  localparam int CW = cntWidth(T3S, TREP);
  localparam logic [CW-1:0] DEB_END  = CW'(T10MS - 1);
  localparam logic [CW-1:0] LONG_END = CW'(T3S - 1);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_END  = CW'(TREP - 1);
`endif

  logic f1, f2;
  logic isH2L, isL2H;
  keyState_e state;
  logic [CW-1:0] cnt;

  assign isH2L = f2 & ~f1;
  assign isL2H = ~f2 & f1;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      f1     <= 1'b1;
      f2     <= 1'b1;
      state  <= IDLE;
      cnt    <= '0;
      oShort <= 1'b0;
      oLong  <= 1'b0;
      oHeld  <= 1'b0;
    end else begin
      f1     <= key;
      f2     <= f1;
      oShort <= 1'b0;
      oLong  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (isH2L) state <= DEB_DN;
        end
        DEB_DN: begin
          if (cnt == DEB_END) begin
            cnt <= '0;
            if (!f1) begin
              state <= HOLD;
              oHeld <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          // A release landing on the threshold cycle still counts as a short click.
          if (isL2H) begin
            oShort <= 1'b1;
            oHeld  <= 1'b0;
            state  <= DEB_UP;
            cnt    <= '0;
          end else if (cnt == LONG_END) begin
            oLong <= 1'b1;
            state <= WAIT_UP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_UP: begin
          if (isL2H) begin
            oHeld <= 1'b0;
            state <= DEB_UP;
            cnt   <= '0;
          end else begin
`ifdef KEY_AUTOREPEAT_EN
            if (cnt == REP_END) begin
              oLong <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
`else
            cnt <= '0;
`endif
          end
        end
        DEB_UP: begin
          if (cnt == DEB_END) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_array_funcmod.sv
// NKEY independent key channels side by side; outputs are per-channel bit vectors.
// Honours KEY_AUTOREPEAT_EN through the channel module.
module key_array_funcmod
  import key_pkg::*;
#(
  parameter int NKEY  = DEF_NKEY,
  parameter int T10MS = DEF_T10MS,
  parameter int T3S   = DEF_T3S,
  parameter int TREP  = DEF_TREP
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [NKEY-1:0] KEY,
  output logic [NKEY-1:0] oShort,
  output logic [NKEY-1:0] oLong,
  output logic [NKEY-1:0] oHeld
);

  for (genvar k = 0; k < NKEY; k++) begin : gChan
    key_chan #(
      .T10MS(T10MS),
      .T3S  (T3S),
      .TREP (TREP)
    ) uChan (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .key   (KEY[k]),
      .oShort(oShort[k]),
      .oLong (oLong[k]),
      .oHeld (oHeld[k])
    );
  end

endmodule

// File: tb/tb_key_array_funcmod.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor pops and compares them.
module tb_key_array_funcmod;

  localparam int NKEY = 2;

  logic            CLOCK = 1'b0;
  logic            RESET;
  logic [NKEY-1:0] KEY;
  logic [NKEY-1:0] oShort, oLong, oHeld;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int             at;
    logic [NKEY-1:0] s;
    logic [NKEY-1:0] l;
  } ev_t;

  ev_t expQ[$];

  key_array_funcmod #(
    .NKEY (NKEY),
    .T10MS(10),
    .T3S  (100),
    .TREP (20)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .KEY   (KEY),
    .oShort(oShort),
    .oLong (oLong),
    .oHeld (oHeld)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic expect_ev(input int at, input logic [NKEY-1:0] s, input logic [NKEY-1:0] l);
    ev_t e;
    e.at = at;
    e.s  = s;
    e.l  = l;
    expQ.push_back(e);
  endtask

  always @(negedge CLOCK) begin
    if ((|oShort) || (|oLong)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got short=%b long=%b at cycle %0d, expected none",
                 oShort, oLong, cyc);
      end else begin
        ev_t e;
        e = expQ.pop_front();
        check("pulse_cycle", cyc, e.at);
        check("pulse_short", int'(oShort), int'(e.s));
        check("pulse_long", int'(oLong), int'(e.l));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    RESET = 1'b0;
    KEY   = '1;
    #1;
    check("rst_short", int'(oShort), 0);
    check("rst_long", int'(oLong), 0);
    check("rst_held", int'(oHeld), 0);
    tick(3);
    RESET = 1'b1;
    tick(5);

    // short click on key0
    p = cyc;
    KEY[0] = 1'b0;
    expect_ev(p + 52, 2'b01, 2'b00);
    tick(11);
    check("t1_held_before_deb", int'(oHeld), 0);
    tick(1);
    check("t1_held_after_deb", int'(oHeld), 1);
    tick(38);
    KEY[0] = 1'b1;
    tick(1);
    check("t1_held_pre_release", int'(oHeld), 1);
    tick(1);
    check("t1_held_released", int'(oHeld), 0);
    tick(30);

    // long press on key0
    p = cyc;
    KEY[0] = 1'b0;
    expect_ev(p + 112, 2'b00, 2'b01);
`ifdef KEY_AUTOREPEAT_EN
    expect_ev(p + 132, 2'b00, 2'b01);
    expect_ev(p + 152, 2'b00, 2'b01);
    expect_ev(p + 172, 2'b00, 2'b01);
    expect_ev(p + 192, 2'b00, 2'b01);
`endif
    tick(200);
    KEY[0] = 1'b1;
    tick(1);
    check("t2_held_long", int'(oHeld), 1);
    tick(1);
    check("t2_held_released", int'(oHeld), 0);
    tick(30);

    // glitch shorter than the debounce window
    KEY[0] = 1'b0;
    tick(5);
    KEY[0] = 1'b1;
    tick(7);
    check("t3_held_glitch", int'(oHeld), 0);
    tick(20);
    check("t3_held_after", int'(oHeld), 0);

    // both keys together
    p = cyc;
    KEY = 2'b00;
    expect_ev(p + 52, 2'b11, 2'b00);
    tick(12);
    check("t4_held_both", int'(oHeld), 3);
    tick(38);
    KEY = 2'b11;
    tick(2);
    check("t4_held_released", int'(oHeld), 0);
    tick(30);

    // bouncy release
    p = cyc;
    KEY[0] = 1'b0;
    expect_ev(p + 52, 2'b01, 2'b00);
    tick(50);
    KEY[0] = 1'b1;
    tick(2);
    KEY[0] = 1'b0;
    tick(2);
    KEY[0] = 1'b1;
    tick(40);
    check("t5_held_after_bounce", int'(oHeld), 0);

    // reset in the middle of a long hold, kept until after the key is released
    p = cyc;
    KEY[0] = 1'b0;
    expect_ev(p + 112, 2'b00, 2'b01);
`ifdef KEY_AUTOREPEAT_EN
    expect_ev(p + 132, 2'b00, 2'b01);
`endif
    tick(149);
    check("t6_held_before_rst", int'(oHeld), 1);
    tick(1);
    RESET = 1'b0;
    #1;
    check("t6_rst_short", int'(oShort), 0);
    check("t6_rst_long", int'(oLong), 0);
    check("t6_rst_held", int'(oHeld), 0);
    tick(50);
    KEY[0] = 1'b1;
    tick(10);
    RESET = 1'b1;
    tick(50);
    check("t6_held_after_rst", int'(oHeld), 0);

    tick(5);
    check("queue_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
